// File: rtl/i2c_slave_block_if.sv
// I2C bus pins seen by a target: SCL/SDA inputs (resolved wire values) and the
// open-drain SDA pull-down enable.
interface i2c_slave_block_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe_o;

    modport master (output scl_i, output sda_i, input sda_oe_o);
    modport slave  (input scl_i, input sda_i, output sda_oe_o);
endinterface

// File: rtl/i2c_slave_block.sv
// Oversampled I2C target with a byte-addressed register file. SCL/SDA are
// synchronised into the core clock; bit events come from the synchronised edges.
module i2c_slave_block #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         PTR_W      = 4
) (
    input  logic             i2c_core_clock_i,
    input  logic             reset_bit_n_i,
    i2c_slave_block_if.slave bus,
    output logic             busy_o,
    output logic             wr_strobe_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    input  logic [PTR_W-1:0] dbg_addr_i,
    output logic [7:0]       dbg_data_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t state, state_nxt;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, start, stop;

    logic [7:0]       mem [DEPTH];
    logic [7:0]       shift, shift_nxt;
    logic [3:0]       bit_cnt, cnt_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             phase, phase_nxt;
    logic             rw, rw_nxt;
    logic             first, first_nxt;
    logic             sda_oe, oe_nxt;
    logic             busy_nxt, strobe_nxt, mem_we;
    logic [PTR_W-1:0] waddr_nxt;
    logic [7:0]       wdata_nxt;
    logic [7:0]       rx_byte;
    logic             addr_match;

    assign scl_rise   = scl_p1 & ~scl_p2;
    assign scl_fall   = ~scl_p1 & scl_p2;
    assign start      = ~sda_p1 & sda_p2 & scl_p1;
    assign stop       = sda_p1 & ~sda_p2 & scl_p1;
    assign rx_byte    = {shift[6:0], sda_p1};
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDR);

    assign bus.sda_oe_o = sda_oe;
    assign dbg_data_o   = mem[dbg_addr_i];

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) state <= IDLE;
        else                state <= state_nxt;
    end

    // START/STOP override any bit event in the same cycle.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:     if (scl_rise && bit_cnt == 4'd7) state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (scl_fall && phase) state_nxt = rw ? TX_BYTE : RX_BYTE;
                RX_BYTE:  if (scl_rise && bit_cnt == 4'd7) state_nxt = RX_ACK;
                RX_ACK:   if (scl_fall && phase) state_nxt = RX_BYTE;
                TX_BYTE:  if (scl_fall && bit_cnt == 4'd8) state_nxt = TX_ACK;
                TX_ACK: begin
                    if (scl_rise && sda_p1)     state_nxt = WAIT_STOP;
                    else if (scl_fall && phase) state_nxt = TX_BYTE;
                end
                default: ;
            endcase
        end
    end

    // phase marks the second half of an ACK slot: ACK driven, or master ACK seen.
    always_comb begin
        shift_nxt  = shift;
        cnt_nxt    = bit_cnt;
        ptr_nxt    = ptr;
        phase_nxt  = phase;
        rw_nxt     = rw;
        first_nxt  = first;
        oe_nxt     = sda_oe;
        busy_nxt   = busy_o;
        mem_we     = 1'b0;
        strobe_nxt = 1'b0;
        waddr_nxt  = wr_addr_o;
        wdata_nxt  = wr_data_o;
        if (stop) begin
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            phase_nxt = 1'b0;
            cnt_nxt   = 4'd0;
        end else if (start) begin
            oe_nxt    = 1'b0;
            phase_nxt = 1'b0;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_nxt = rx_byte;
                    cnt_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        cnt_nxt   = 4'd0;
                        phase_nxt = 1'b0;
                        if (addr_match) begin
                            rw_nxt    = rx_byte[0];
                            busy_nxt  = 1'b1;
                            first_nxt = 1'b1;
                        end else begin
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_nxt = rx_byte;
                    cnt_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        cnt_nxt   = 4'd0;
                        phase_nxt = 1'b0;
                        if (first) begin
                            ptr_nxt   = rx_byte[PTR_W-1:0];
                            first_nxt = 1'b0;
                        end else begin
                            mem_we     = 1'b1;
                            strobe_nxt = 1'b1;
                            waddr_nxt  = ptr;
                            wdata_nxt  = rx_byte;
                            ptr_nxt    = ptr + PTR_W'(1);
                        end
                    end
                end
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!phase) begin
                        oe_nxt    = 1'b1;
                        phase_nxt = 1'b1;
                    end else begin
                        phase_nxt = 1'b0;
                        cnt_nxt   = 4'd0;
                        if (state == ADDR_ACK && rw) begin
                            shift_nxt = mem[ptr];
                            oe_nxt    = ~mem[ptr][7];
                        end else begin
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) cnt_nxt = bit_cnt + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_nxt    = 1'b0;
                            phase_nxt = 1'b0;
                        end else begin
                            shift_nxt = {shift[6:0], 1'b0};
                            oe_nxt    = ~shift[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        ptr_nxt   = ptr + PTR_W'(1);
                        phase_nxt = ~sda_p1;
                    end else if (scl_fall && phase) begin
                        shift_nxt = mem[ptr];
                        oe_nxt    = ~mem[ptr][7];
                        cnt_nxt   = 4'd0;
                        phase_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) begin
            scl_p0      <= 1'b0;
            scl_p1      <= 1'b0;
            scl_p2      <= 1'b0;
            sda_p0      <= 1'b0;
            sda_p1      <= 1'b0;
            sda_p2      <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            ptr         <= '0;
            phase       <= 1'b0;
            rw          <= 1'b0;
            first       <= 1'b0;
            sda_oe      <= 1'b0;
            busy_o      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            scl_p0      <= bus.scl_i;
            scl_p1      <= scl_p0;
            scl_p2      <= scl_p1;
            sda_p0      <= bus.sda_i;
            sda_p1      <= sda_p0;
            sda_p2      <= sda_p1;
            shift       <= shift_nxt;
            bit_cnt     <= cnt_nxt;
            ptr         <= ptr_nxt;
            phase       <= phase_nxt;
            rw          <= rw_nxt;
            first       <= first_nxt;
            sda_oe      <= oe_nxt;
            busy_o      <= busy_nxt;
            wr_strobe_o <= strobe_nxt;
            wr_addr_o   <= waddr_nxt;
            wr_data_o   <= wdata_nxt;
            if (mem_we) mem[ptr] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_i2c_slave_block.sv
// Directed bench for i2c_slave_block: a bit-banged I2C master with an
// open-drain SDA model and hand-computed expectations.
module tb_i2c_slave_block;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl, m_sda;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy, wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    logic [3:0] st_addr[$];
    logic [7:0] st_data[$];

    always #5 clk = ~clk;

    i2c_slave_block_if i2c();
    assign i2c.scl_i = m_scl;
    assign i2c.sda_i = m_sda & ~i2c.sda_oe_o;

    i2c_slave_block #(.SLAVE_ADDR(7'h50), .DEPTH(16), .PTR_W(4)) dut (
        .i2c_core_clock_i(clk),
        .reset_bit_n_i   (rst_n),
        .bus             (i2c),
        .busy_o          (busy),
        .wr_strobe_o     (wr_strobe),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .dbg_addr_i      (dbg_addr),
        .dbg_data_o      (dbg_data)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            st_addr.push_back(wr_addr);
            st_data.push_back(wr_data);
        end
        if (i2c.sda_oe_o) oe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0; tick(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        ack = i2c.sda_i; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; tick(Q);
            m_scl = 1'b1; tick(Q);
            d[i] = i2c.sda_i; tick(Q);
            m_scl = 1'b0; tick(Q);
        end
        m_sda = ack;  tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
        m_sda = 1'b1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         n0, ob;

        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; dbg_addr = '0;
        tick(4);
        chk("rst_sda_oe", i2c.sda_oe_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        peek(4'd7, d); chk("rst_mem7", d, 8'h00);
        rst_n = 1'b1;
        tick(4);

        // Test 1: pointer 3, write 5A and C3
        n0 = st_addr.size();
        i2c_start();
        send_byte(8'hA0, ack); chk("t1_ack_addr", ack, 0);
        chk("t1_busy", busy, 1);
        send_byte(8'h03, ack); chk("t1_ack_ptr", ack, 0);
        send_byte(8'h5A, ack); chk("t1_ack_d0", ack, 0);
        send_byte(8'hC3, ack); chk("t1_ack_d1", ack, 0);
        i2c_stop();
        chk("t1_busy_after_stop", busy, 0);
        chk("t1_strobes", st_addr.size() - n0, 2);
        chk("t1_st0_addr", st_addr[n0], 4'd3);
        chk("t1_st0_data", st_data[n0], 8'h5A);
        chk("t1_st1_addr", st_addr[n0+1], 4'd4);
        chk("t1_st1_data", st_data[n0+1], 8'hC3);
        peek(4'd3, d); chk("t1_mem3", d, 8'h5A);
        peek(4'd4, d); chk("t1_mem4", d, 8'hC3);

        // Test 2: pointer write, repeated START, read two bytes
        i2c_start();
        send_byte(8'hA0, ack); chk("t2_ack_addr_w", ack, 0);
        send_byte(8'h03, ack); chk("t2_ack_ptr", ack, 0);
        i2c_start();
        send_byte(8'hA1, ack); chk("t2_ack_addr_r", ack, 0);
        read_byte(1'b0, d); chk("t2_rd0", d, 8'h5A);
        read_byte(1'b1, d); chk("t2_rd1", d, 8'hC3);
        tick(2);
        chk("t2_sda_released", i2c.sda_oe_o, 0);
        chk("t2_busy_until_stop", busy, 1);
        chk("t2_ptr", dut.ptr, 4'd5);
        i2c_stop();
        chk("t2_busy_after_stop", busy, 0);

        // Test 3: wrong address is ignored
        n0 = st_addr.size();
        ob = oe_cnt;
        i2c_start();
        send_byte(8'hA2, ack); chk("t3_nack_addr", ack, 1);
        chk("t3_busy", busy, 0);
        send_byte(8'h11, ack); chk("t3_nack_data", ack, 1);
        i2c_stop();
        chk("t3_oe_never", oe_cnt - ob, 0);
        chk("t3_no_strobe", st_addr.size() - n0, 0);
        peek(4'd1, d); chk("t3_mem1", d, 8'h00);
        peek(4'd3, d); chk("t3_mem3", d, 8'h5A);

        // Test 4: pointer wrap and pointer upper bits ignored
        n0 = st_addr.size();
        i2c_start();
        send_byte(8'hA0, ack); chk("t4_ack_addr", ack, 0);
        send_byte(8'h0F, ack);
        send_byte(8'h01, ack);
        send_byte(8'h02, ack);
        send_byte(8'h03, ack); chk("t4_ack_last", ack, 0);
        i2c_stop();
        peek(4'd15, d); chk("t4_mem15", d, 8'h01);
        peek(4'd0, d);  chk("t4_mem0", d, 8'h02);
        peek(4'd1, d);  chk("t4_mem1", d, 8'h03);
        chk("t4_st0_addr", st_addr[n0], 4'd15);
        chk("t4_st1_addr", st_addr[n0+1], 4'd0);
        chk("t4_st2_addr", st_addr[n0+2], 4'd1);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h23, ack);
        i2c_stop();
        chk("t4_ptr_mod", dut.ptr, 4'd3);
        i2c_start();
        send_byte(8'hA1, ack); chk("t4_ack_rd", ack, 0);
        read_byte(1'b1, d); chk("t4_rd_mem3", d, 8'h5A);
        i2c_stop();

        // Test 5: STOP after four bits of a data byte
        n0 = st_addr.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h08, ack);
        send_bits(8'hFF, 4);
        i2c_stop();
        chk("t5_state_idle", 32'(dut.state), 0);
        chk("t5_sda_oe", i2c.sda_oe_o, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_strobe", st_addr.size() - n0, 0);
        peek(4'd8, d); chk("t5_mem8_untouched", d, 8'h00);
        i2c_start();
        send_byte(8'hA0, ack); chk("t5_ack_addr2", ack, 0);
        send_byte(8'h08, ack);
        send_byte(8'h99, ack); chk("t5_ack_d", ack, 0);
        i2c_stop();
        chk("t5_one_strobe", st_addr.size() - n0, 1);
        peek(4'd8, d); chk("t5_mem8", d, 8'h99);

        // Test 6: asynchronous reset while ACK is driven
        i2c_start();
        send_bits(8'hA0, 8);
        m_sda = 1'b1;
        tick(Q);
        chk("t6_acking", i2c.sda_oe_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_release", i2c.sda_oe_o, 0);
        chk("t6_busy", busy, 0);
        peek(4'd3, d);  chk("t6_mem3", d, 8'h00);
        peek(4'd15, d); chk("t6_mem15", d, 8'h00);
        tick(2);
        m_scl = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
